// File: rtl/wsg_reg_sequencer.sv
// rtl/wsg_reg_sequencer.sv - WSG register-file bus initiator
// Buffers whole-channel updates and serialises them into nibble writes.
module wsg_reg_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int WR_CYCLES      = 2,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic                         CLK48M,
  input  logic                         RESET_N,
  input  logic                         REQ_VALID,
  output logic                         REQ_READY,
  input  logic [1:0]                   REQ_CH,
  input  logic [2:0]                   REQ_WAVE,
  input  logic [3:0]                   REQ_VOL,
  input  logic [19:0]                  REQ_FREQ,
  output logic [4:0]                   ADRS,
  output logic [3:0]                   DATA,
  output logic                         WR,
  output logic                         BUSY,
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WR_CYCLES + 1);
  localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, SETUP, STROBE, HOLD} state_t;

  state_t      state;
  logic [28:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic        push, pop;

  logic [1:0]  w_ch;
  logic [2:0]  w_wave;
  logic [3:0]  w_vol;
  logic [19:0] w_freq;
  logic [2:0]  idx;
  logic [CW-1:0] cnt;
  logic [3:0]  shadow [19];

  logic [4:0]  cur_adrs;
  logic [3:0]  cur_nib;
  logic [2:0]  last_idx;
  logic [19:0] freq_sh;
  logic        skip;

  // Nibble registers 10..1F map to slots 0..15; the three wave registers follow.
  function automatic logic [4:0] slot(input logic [4:0] a);
    case (a)
      5'h05:   slot = 5'd16;
      5'h0A:   slot = 5'd17;
      5'h0F:   slot = 5'd18;
      default: slot = {1'b0, a[3:0]};
    endcase
  endfunction

  assign REQ_READY = (FIFO_LEVEL != FULL_LEVEL);
  assign push      = REQ_VALID && REQ_READY;
  assign pop       = (state == IDLE) && (FIFO_LEVEL != '0);
  assign BUSY      = (FIFO_LEVEL != '0) || (state != IDLE);

  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {REQ_CH, REQ_WAVE, REQ_VOL, REQ_FREQ};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
      else if (pop && !push)
        FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
    end
  end

  always_comb begin
    cur_adrs = '0;
    cur_nib  = '0;
    last_idx = 3'd5;
    freq_sh  = w_freq >> {idx, 2'b00};
    case (w_ch)
      2'd0: begin
        last_idx = 3'd6;
        case (idx)
          3'd5:    begin cur_adrs = 5'h05; cur_nib = {1'b0, w_wave}; end
          3'd6:    begin cur_adrs = 5'h15; cur_nib = w_vol; end
          default: begin cur_adrs = 5'h10 + {2'b00, idx}; cur_nib = freq_sh[3:0]; end
        endcase
      end
      2'd1: begin
        case (idx)
          3'd4:    begin cur_adrs = 5'h0A; cur_nib = {1'b0, w_wave}; end
          3'd5:    begin cur_adrs = 5'h1A; cur_nib = w_vol; end
          default: begin cur_adrs = 5'h16 + {2'b00, idx}; cur_nib = freq_sh[3:0]; end
        endcase
      end
      default: begin
        case (idx)
          3'd4:    begin cur_adrs = 5'h0F; cur_nib = {1'b0, w_wave}; end
          3'd5:    begin cur_adrs = 5'h1F; cur_nib = w_vol; end
          default: begin cur_adrs = 5'h1B + {2'b00, idx}; cur_nib = freq_sh[3:0]; end
        endcase
      end
    endcase
    skip = (SKIP_UNCHANGED != 0) && (cur_nib == shadow[slot(cur_adrs)]);
  end

  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      state  <= IDLE;
      ADRS   <= '0;
      DATA   <= '0;
      WR     <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      w_ch   <= '0;
      w_wave <= '0;
      w_vol  <= '0;
      w_freq <= '0;
      for (int i = 0; i < 19; i++)
        shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {w_ch, w_wave, w_vol, w_freq} <= fifo_mem[rd_ptr];
            state <= LOAD;
          end
        end
        LOAD: begin
          idx   <= '0;
          state <= (w_ch == 2'd3) ? IDLE : SCAN;
        end
        SCAN: begin
          if (skip) begin
            if (idx == last_idx)
              state <= IDLE;
            else
              idx <= idx + 1'b1;
          end else begin
            ADRS  <= cur_adrs;
            DATA  <= cur_nib;
            state <= SETUP;
          end
        end
        SETUP: begin
          WR    <= 1'b1;
          cnt   <= '0;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == CW'(WR_CYCLES - 1)) begin
            WR    <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          shadow[slot(ADRS)] <= DATA;
          if (idx == last_idx) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wsg_reg_sequencer.sv
// tb/tb_wsg_reg_sequencer.sv - self-checking bench for wsg_reg_sequencer
module tb_wsg_reg_sequencer;
  localparam int DEPTH = 4;
  localparam int WRC   = 2;
  localparam int SKIP  = 1;

  logic        CLK48M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_CH = '0;
  logic [2:0]  REQ_WAVE = '0;
  logic [3:0]  REQ_VOL = '0;
  logic [19:0] REQ_FREQ = '0;
  logic [4:0]  ADRS;
  logic [3:0]  DATA;
  logic        WR;
  logic        BUSY;
  logic [2:0]  FIFO_LEVEL;

  wsg_reg_sequencer #(.FIFO_DEPTH(DEPTH), .WR_CYCLES(WRC), .SKIP_UNCHANGED(SKIP)) dut (
    .CLK48M(CLK48M), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_CH(REQ_CH), .REQ_WAVE(REQ_WAVE), .REQ_VOL(REQ_VOL), .REQ_FREQ(REQ_FREQ),
    .ADRS(ADRS), .DATA(DATA), .WR(WR), .BUSY(BUSY), .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK48M = ~CLK48M;

  typedef struct {
    logic [1:0]  ch;
    logic [2:0]  wave;
    logic [3:0]  vol;
    logic [19:0] freq;
    int          exp_wr;
    int          exp_cyc;
  } vec_t;

  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [8:0]  sb[$];
  logic [3:0]  m_shadow[32];
  int          wr_pulses = 0;
  logic [4:0]  last_adrs;
  logic [3:0]  last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference item lists: expected writes are queued as each request is accepted.
  task automatic model_push(input logic [1:0] ch, input logic [2:0] w, input logic [3:0] v,
                            input logic [19:0] f);
    logic [4:0] a [7];
    logic [3:0] d [7];
    int n;
    n = 0;
    if (ch == 2'd0) begin
      a = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h05, 5'h15};
      d = '{f[3:0], f[7:4], f[11:8], f[15:12], f[19:16], {1'b0, w}, v};
      n = 7;
    end else if (ch == 2'd1) begin
      a = '{5'h16, 5'h17, 5'h18, 5'h19, 5'h0A, 5'h1A, 5'h00};
      d = '{f[3:0], f[7:4], f[11:8], f[15:12], {1'b0, w}, v, 4'h0};
      n = 6;
    end else if (ch == 2'd2) begin
      a = '{5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h0F, 5'h1F, 5'h00};
      d = '{f[3:0], f[7:4], f[11:8], f[15:12], {1'b0, w}, v, 4'h0};
      n = 6;
    end
    for (int i = 0; i < n; i++) begin
      if (SKIP == 0 || d[i] != m_shadow[a[i]]) begin
        sb.push_back({a[i], d[i]});
        m_shadow[a[i]] = d[i];
      end
    end
  endtask

  task automatic push_req(input logic [1:0] ch, input logic [2:0] w, input logic [3:0] v,
                          input logic [19:0] f, output int waited);
    REQ_VALID = 1'b1;
    REQ_CH = ch; REQ_WAVE = w; REQ_VOL = v; REQ_FREQ = f;
    waited = 0;
    while (!REQ_READY && waited < 500) begin
      @(posedge CLK48M); #1;
      waited++;
    end
    if (waited >= 500) check("push_timeout", 32'(REQ_READY), 32'd1);
    model_push(ch, w, v, f);
    @(posedge CLK48M); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (BUSY && cyc < 400) begin
      @(posedge CLK48M); #1;
      cyc++;
    end
    check("busy_clears", 32'(BUSY), 32'd0);
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 32; i++) m_shadow[i] = 4'h0;
  endtask

  logic       prev_wr = 1'b0;
  int         hi_cnt = 0;
  int         lo_cnt = 100;
  logic [4:0] hold_a;
  logic [3:0] hold_d;

  always @(negedge CLK48M) begin
    if (!RESET_N) begin
      prev_wr = 1'b0;
      hi_cnt  = 0;
      lo_cnt  = 100;
    end else begin
      if (WR && !prev_wr) begin
        wr_pulses++;
        check("wr_gap", 32'(lo_cnt >= 2), 32'd1);
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("write_adrs_data", 32'({ADRS, DATA}), 32'(sb.pop_front()));
        hold_a = ADRS; hold_d = DATA;
        last_adrs = ADRS; last_data = DATA;
        hi_cnt = 1;
      end else if (WR) begin
        hi_cnt++;
        check("adrs_data_stable", 32'({ADRS, DATA}), 32'({hold_a, hold_d}));
      end else if (prev_wr) begin
        check("wr_width", 32'(hi_cnt), 32'(WRC));
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      prev_wr = WR;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, waited, p0;

    vecs[0] = '{2'd0, 3'd5, 4'hA, 20'h12345, 7, 37};
    vecs[1] = '{2'd0, 3'd5, 4'hA, 20'h12345, 0, 9};
    vecs[2] = '{2'd0, 3'd5, 4'hA, 20'h12340, 1, 13};
    vecs[3] = '{2'd2, 3'd0, 4'h7, 20'h00000, 1, 12};
    vecs[4] = '{2'd1, 3'd0, 4'h3, 20'hF00F0, 2, 16};
    vecs[5] = '{2'd3, 3'd7, 4'h7, 20'hFFFFF, 0, 2};
    vecs[6] = '{2'd1, 3'd7, 4'h3, 20'h00000, 2, 16};

    clear_model();
    repeat (3) @(posedge CLK48M);
    #1;
    check("rst_adrs", 32'(ADRS), 32'd0);
    check("rst_data", 32'(DATA), 32'd0);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_level", 32'(FIFO_LEVEL), 32'd0);
    check("rst_ready", 32'(REQ_READY), 32'd1);
    RESET_N = 1'b1;
    @(posedge CLK48M); #1;

    for (int i = 0; i < 7; i++) begin
      p0 = wr_pulses;
      push_req(vecs[i].ch, vecs[i].wave, vecs[i].vol, vecs[i].freq, waited);
      wait_idle(cyc);
      @(negedge CLK48M);
      check($sformatf("vec%0d_writes", i), 32'(wr_pulses - p0), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_sb_drained", i), 32'(sb.size()), 32'd0);
      @(posedge CLK48M); #1;
    end

    // One request in flight, then five more back-to-back against a depth-4 FIFO.
    push_req(2'd0, 3'd2, 4'h1, 20'hABCDE, waited);
    push_req(2'd1, 3'd3, 4'h9, 20'h12345, waited);
    check("push_pop_same_cycle_level", 32'(FIFO_LEVEL), 32'd1);
    push_req(2'd2, 3'd6, 4'h4, 20'h0ABCD, waited);
    push_req(2'd0, 3'd1, 4'h1, 20'h11111, waited);
    push_req(2'd1, 3'd5, 4'h2, 20'h54321, waited);
    check("full_level", 32'(FIFO_LEVEL), 32'd4);
    check("full_ready_low", 32'(REQ_READY), 32'd0);
    push_req(2'd2, 3'd0, 4'h0, 20'h00000, waited);
    check("fifth_waited_for_pop", 32'(waited > 0), 32'd1);
    check("refill_level", 32'(FIFO_LEVEL), 32'd4);
    wait_idle(cyc);
    @(negedge CLK48M);
    check("b2b_sb_drained", 32'(sb.size()), 32'd0);
    @(posedge CLK48M); #1;

    // Reset while WR is high, with a second request still queued.
    push_req(2'd0, 3'd5, 4'hA, 20'h12345, waited);
    push_req(2'd1, 3'd1, 4'h1, 20'h11111, waited);
    cyc = 0;
    while (!WR && cyc < 100) begin
      @(posedge CLK48M); #1;
      cyc++;
    end
    check("wr_seen_before_reset", 32'(WR), 32'd1);
    RESET_N = 1'b0;
    @(posedge CLK48M); #1;
    check("midreset_wr", 32'(WR), 32'd0);
    check("midreset_level", 32'(FIFO_LEVEL), 32'd0);
    check("midreset_busy", 32'(BUSY), 32'd0);
    check("midreset_ready", 32'(REQ_READY), 32'd1);
    clear_model();
    @(posedge CLK48M); #1;
    RESET_N = 1'b1;
    @(posedge CLK48M); #1;

    p0 = wr_pulses;
    push_req(2'd0, 3'd5, 4'hA, 20'h12345, waited);
    wait_idle(cyc);
    @(negedge CLK48M);
    check("resend_writes", 32'(wr_pulses - p0), 32'd7);
    check("resend_cycles", 32'(cyc), 32'd37);
    @(posedge CLK48M); #1;

    // Invalid channel is dropped; the following ch2 update writes only its volume.
    p0 = wr_pulses;
    push_req(2'd3, 3'd5, 4'h5, 20'h55555, waited);
    push_req(2'd2, 3'd0, 4'h7, 20'h00000, waited);
    wait_idle(cyc);
    @(negedge CLK48M);
    check("ch3_then_ch2_writes", 32'(wr_pulses - p0), 32'd1);
    check("ch2_vol_write", 32'({last_adrs, last_data}), 32'({5'h1F, 4'h7}));
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
